// File: rtl/wb_pkg.sv
// ============================================================================
// Module : wb_pkg
// Brief  : Shared state encoding and default widths for the Wishbone master.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int WB_DATA_WIDTH_DEF  = 32;
    localparam int WB_ADDR_WIDTH_DEF  = 11;
    localparam int GRANULARITY_DEF    = 8;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUS  = 1'b1
    } wb_state_e;

    // Counter must be able to represent TIMEOUT_CYCLES itself (saturation value).
    function automatic int cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_master_if.sv
// ============================================================================
// Module : wb_master_if
// Brief  : Wishbone classic bus bundle with master and slave views.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface wb_master_if
    import wb_pkg::*;
#(
    parameter int WB_DATA_WIDTH = WB_DATA_WIDTH_DEF,
    parameter int WB_ADDR_WIDTH = WB_ADDR_WIDTH_DEF,
    parameter int SEL_WIDTH     = WB_DATA_WIDTH_DEF / GRANULARITY_DEF
);
    logic                     cyc_o;
    logic                     stb_o;
    logic                     we_o;
    logic [WB_ADDR_WIDTH-1:0] addr_o;
    logic [WB_DATA_WIDTH-1:0] data_o;
    logic [SEL_WIDTH-1:0]     sel_o;
    logic [WB_DATA_WIDTH-1:0] data_i;
    logic                     ack_i;

    modport master (
        output cyc_o, stb_o, we_o, addr_o, data_o, sel_o,
        input  data_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, addr_o, data_o, sel_o,
        output data_i, ack_i
    );

endinterface

`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
// ============================================================================
// Module : wb_timeout_cnt
// Brief  : Saturating cycle counter flagging the last cycle before timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_timeout_cnt
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic clear_i,
    input  wire logic enable_i,
    output logic      expire_o
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != c_limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == c_last);

endmodule

`default_nettype wire

// File: rtl/wb_master.sv
// ============================================================================
// Module : wb_master
// Brief  : Single-outstanding Wishbone classic master with ack timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_master
    import wb_pkg::*;
#(
    parameter int WB_DATA_WIDTH  = WB_DATA_WIDTH_DEF,
    parameter int WB_ADDR_WIDTH  = WB_ADDR_WIDTH_DEF,
    parameter int GRANULARITY    = GRANULARITY_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  wire logic                                   clk_i,
    input  wire logic                                   rst_i,
    input  wire logic                                   req_i,
    input  wire logic                                   req_we_i,
    input  wire logic [WB_ADDR_WIDTH-1:0]               req_addr_i,
    input  wire logic [WB_DATA_WIDTH-1:0]               req_data_i,
    input  wire logic [WB_DATA_WIDTH/GRANULARITY-1:0]   req_sel_i,
    output logic                                        ready_o,
    output logic                                        done_o,
    output logic                                        err_o,
    output logic [WB_DATA_WIDTH-1:0]                    rdata_o,
    wb_master_if.master                                 wb
);

    localparam int SEL_W = WB_DATA_WIDTH / GRANULARITY;

    wb_state_e                state_q, state_d;
    logic                     cyc_q, cyc_d;
    logic                     stb_q, stb_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WB_DATA_WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic w_cnt_clear;
    logic w_cnt_en;
    logic w_expire;

    wb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (w_cnt_clear),
        .enable_i (w_cnt_en),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        sel_d       = sel_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d        = req_we_i;
                    addr_d      = req_addr_i;
                    data_d      = req_data_i;
                    sel_d       = req_sel_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    w_cnt_clear = 1'b1;
                    state_d     = BUS;
                end
            end
            BUS: begin
                // Ack takes priority over a coincident timeout.
                if (wb.ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (!we_q) begin
                        rdata_d = wb.data_i;
                    end
                end else if (w_expire) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobe drops combinationally in the ack cycle so a registered-ack
    // slave never sees a second request.
    assign wb.stb_o  = stb_q & ~wb.ack_i;
    assign wb.cyc_o  = cyc_q;
    assign wb.we_o   = we_q;
    assign wb.addr_o = addr_q;
    assign wb.data_o = data_q;
    assign wb.sel_o  = sel_q;

    assign ready_o = (state_q == IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_master.sv
// ============================================================================
// Module : tb_wb_master
// Brief  : Scoreboard bench for wb_master with a programmable-latency slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_master;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int SW = 4;
    localparam int TO = 16;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] sel;
        int            ack_at;
        logic [DW-1:0] sdata;
        logic          err;
        logic [DW-1:0] rdata;
        int            len;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_i = 1'b0;
    logic          req_we_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_data_i = '0;
    logic [SW-1:0] req_sel_i = '0;
    logic          ready_o;
    logic          done_o;
    logic          err_o;
    logic [DW-1:0] rdata_o;

    wb_master_if #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .SEL_WIDTH(SW)) wb ();

    wb_master #(
        .WB_DATA_WIDTH  (DW),
        .WB_ADDR_WIDTH  (AW),
        .GRANULARITY    (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .req_we_i   (req_we_i),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .req_sel_i  (req_sel_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .wb         (wb)
    );

    always #5 clk_i = ~clk_i;

    exp_t          sb[$];
    int            n_compared   = 0;
    int            n_mismatched = 0;
    logic [DW-1:0] model_rdata  = '0;
    int            bus_cnt      = 0;
    int            last_len     = 0;
    logic          force_ack    = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slave model and output monitor, both working at the falling edge.
    initial begin
        wb.ack_i  = 1'b0;
        wb.data_i = '0;
        forever begin
            @(negedge clk_i);
            if (wb.cyc_o) begin
                bus_cnt++;
                if (sb.size() > 0 && sb[0].ack_at == bus_cnt) begin
                    wb.ack_i  = 1'b1;
                    wb.data_i = sb[0].sdata;
                end else begin
                    wb.ack_i  = force_ack;
                    wb.data_i = 32'hBAD0_BAD0;
                end
            end else begin
                if (bus_cnt != 0) last_len = bus_cnt;
                bus_cnt   = 0;
                wb.ack_i  = force_ack;
                wb.data_i = 32'h0BAD_0BAD;
            end
            #1;
            if (wb.cyc_o && bus_cnt == 1 && !wb.ack_i)
                check_eq("stb_first_cycle", wb.stb_o, 1);
            if (wb.cyc_o && wb.ack_i && sb.size() > 0) begin
                check_eq("stb_in_ack_cycle", wb.stb_o, 0);
                check_eq("ready_in_bus", ready_o, 0);
                check_eq("we_hold", wb.we_o, sb[0].we);
                check_eq("addr_hold", wb.addr_o, sb[0].addr);
                check_eq("data_hold", wb.data_o, sb[0].wdata);
                check_eq("sel_hold", wb.sel_o, sb[0].sel);
            end
            if (err_o) check_eq("err_with_done", done_o, 1);
            if (done_o) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", done_o, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("err", err_o, e.err);
                    check_eq("rdata", rdata_o, e.rdata);
                    check_eq("cyc_len", last_len, e.len);
                    check_eq("cyc_low_at_done", wb.cyc_o, 0);
                end
            end
        end
    end

    // Queues the expected outcome, raises req_i and waits for acceptance.
    task automatic submit(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] sel, input int ack_at, input logic [DW-1:0] sdata);
        exp_t e;
        logic rdy;
        logic acc;
        e.we = we; e.addr = addr; e.wdata = wdata; e.sel = sel;
        e.ack_at = ack_at; e.sdata = sdata;
        e.err = !(ack_at >= 1 && ack_at <= TO);
        e.len = e.err ? TO : ack_at;
        if (!we && !e.err) model_rdata = sdata;
        e.rdata = model_rdata;
        sb.push_back(e);
        req_we_i = we; req_addr_i = addr; req_data_i = wdata; req_sel_i = sel;
        req_i = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 64 && !acc; n++) begin
            rdy = ready_o;
            @(negedge clk_i);
            if (rdy) acc = 1'b1;
        end
        check_eq("accepted", acc, 1);
        check_eq("cyc_after_accept", wb.cyc_o, 1);
        check_eq("addr_latched", wb.addr_o, addr);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 64 && sb.size() > 0; n++) begin
            @(negedge clk_i);
            #2;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    initial begin
        #2;
        check_eq("rst_cyc", wb.cyc_o, 0);
        check_eq("rst_stb", wb.stb_o, 0);
        check_eq("rst_we", wb.we_o, 0);
        check_eq("rst_addr", wb.addr_o, 0);
        check_eq("rst_data", wb.data_o, 0);
        check_eq("rst_sel", wb.sel_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_rdata", rdata_o, 0);
        check_eq("rst_ready", ready_o, 1);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Write, ack on 3rd cycle
        submit(1'b1, 11'h400, 32'hDEAD_BEEF, 4'hF, 3, 32'h1111_1111);
        req_i = 1'b0;
        wait_drain();

        // Read with data capture
        submit(1'b0, 11'h004, 32'h0, 4'hF, 2, 32'h1234_5678);
        req_i = 1'b0;
        wait_drain();

        // No ack: timeout
        submit(1'b0, 11'h008, 32'h0, 4'hF, 0, 32'h5555_5555);
        req_i = 1'b0;
        wait_drain();

        // Ack on the final permitted cycle
        submit(1'b0, 11'h00C, 32'h0, 4'hF, TO, 32'hA5A5_0F0F);
        req_i = 1'b0;
        wait_drain();

        // Back-to-back with req_i held, then a stray pulse during BUS
        submit(1'b0, 11'h010, 32'h0, 4'hF, 1, 32'hCAFE_F00D);
        submit(1'b1, 11'h020, 32'h7777_8888, 4'h3, 3, 32'h0);
        req_i = 1'b0;
        @(negedge clk_i);
        req_addr_i = 11'h3FF; req_we_i = 1'b0; req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        wait_drain();

        // Ack while idle is ignored
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            #2;
            check_eq("idle_ack_ready", ready_o, 1);
            check_eq("idle_ack_cyc", wb.cyc_o, 0);
        end
        force_ack = 1'b0;
        @(negedge clk_i);

        // Short write leaves rdata untouched
        submit(1'b1, 11'h100, 32'h0BAD_CAFE, 4'h3, 1, 32'h9999_9999);
        req_i = 1'b0;
        wait_drain();

        // Reset mid-BUS aborts silently
        submit(1'b0, 11'h200, 32'h0, 4'hF, 0, 32'h0);
        req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("abort_cyc", wb.cyc_o, 0);
        check_eq("abort_stb", wb.stb_o, 0);
        check_eq("abort_done", done_o, 0);
        sb.delete();
        model_rdata = '0;
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        check_eq("post_rst_ready", ready_o, 1);
        check_eq("post_rst_rdata", rdata_o, 0);
        repeat (3) @(negedge clk_i);

        // Operation resumes after reset
        submit(1'b0, 11'h044, 32'h0, 4'hC, 4, 32'h0F1E_2D3C);
        req_i = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
